// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S multi-cycle control unit.
//   decoded_instruction_type : IR decode supplied by the datapath. It includes
//                              NOP and the branch family. Codes 16..31 are
//                              unassigned and are treated as NOP.
//   alu_op_t                 : 2-bit ALU operation code.
//   ctrl_t                   : bundle of every control output, registered as one.
//   alu_op_of()              : maps an ALU-class instruction to its op code.
package k_and_s_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic    branch;
    logic    pc_enable;
    logic    ir_enable;
    logic    addr_sel;
    logic    c_sel;
    alu_op_t operation;
    logic    write_reg_enable;
    logic    flags_reg_enable;
    logic    ram_write_enable;
    logic    halt;
  } ctrl_t;

  // MOVE and anything that is not an arithmetic/logic op pass the operand
  // through the OR path.
  function automatic alu_op_t alu_op_of(input decoded_instruction_type di);
    alu_op_t op;
    case (di)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit loadable down-counter with a terminal flag.
//   clk_i, rst_i : clock, asynchronous active-high reset (count clears to 0).
//   load_i       : reload count with load_val_i on the next edge; otherwise
//                  the count decrements, wrapping modulo 16.
//   load_val_i   : reload value.
//   term_val_i   : count value at which term_o is raised.
//   term_o       : count equals term_val_i in the current cycle.
module wait_counter
  import k_and_s_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic [WAIT_W-1:0] term_val_i,
  output logic              term_o
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = load_i ? load_val_i : count_q - {{(WAIT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == term_val_i);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit for the K-and-S processor.
// Sequences fetch / decode / execute with MEM_WAIT extra RAM read cycles,
// handles unconditional and flag-driven branches, and counts instructions
// decoded since reset.
//   clk, rst                  : clock, asynchronous active-high reset.
//   decoded_instruction       : current IR decode from the datapath.
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow           : registered datapath flags.
//   branch, pc_enable,
//   ir_enable, addr_sel,
//   c_sel, operation,
//   write_reg_enable,
//   flags_reg_enable,
//   ram_write_enable, halt    : registered control outputs (Moore on state).
//   instr_count               : instructions decoded since reset, wrapping.
module control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    S_FETCH       = 4'd0,
    S_LOAD_IR     = 4'd1,
    S_DECODE      = 4'd2,
    S_LOAD_WAIT   = 4'd3,
    S_LOAD_WB     = 4'd4,
    S_STORE_WR    = 4'd5,
    S_ALU_WB      = 4'd6,
    S_BRANCH_TAKE = 4'd7,
    S_HALTED      = 4'd8
  } state_t;

  // The wait counter restarts at 0 on every state entry and counts down,
  // wrapping. After N cycles in a state it reads -(N-1) mod 16, so a state
  // lasting N cycles leaves when the count equals that value.
  //   FETCH     lasts MEM_WAIT+1 cycles -> terminal value -MEM_WAIT
  //   LOAD_WAIT lasts MEM_WAIT   cycles -> terminal value 1-MEM_WAIT
  localparam int WRAP         = 2 ** WAIT_W;
  localparam int FETCH_TERM_I = (WRAP - MEM_WAIT) % WRAP;
  localparam int LW_TERM_I    = (WRAP + 1 - MEM_WAIT) % WRAP;
  localparam logic [WAIT_W-1:0] FETCH_TERM = FETCH_TERM_I[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] LW_TERM    = LW_TERM_I[WAIT_W-1:0];

  state_t            state_q;
  state_t            state_d;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  instr_count_q;
  logic              wc_load;
  logic              wc_term;
  logic [WAIT_W-1:0] wc_term_val;

  // Carry-out style flag is not used by any branch condition.
  logic unused_flag;
  assign unused_flag = unsigned_overflow;

  function automatic state_t dispatch(
    input decoded_instruction_type di,
    input logic                    z,
    input logic                    n,
    input logic                    v
  );
    state_t nxt;
    case (di)
      I_HALT:                              nxt = S_HALTED;
      I_LOAD:                              nxt = (MEM_WAIT > 0) ? S_LOAD_WAIT : S_LOAD_WB;
      I_STORE:                             nxt = S_STORE_WR;
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE:   nxt = S_ALU_WB;
      I_BRANCH:                            nxt = S_BRANCH_TAKE;
      I_BZERO:                             nxt = z  ? S_BRANCH_TAKE : S_FETCH;
      I_BNZERO:                            nxt = !z ? S_BRANCH_TAKE : S_FETCH;
      I_BNEG:                              nxt = n  ? S_BRANCH_TAKE : S_FETCH;
      I_BNNEG:                             nxt = !n ? S_BRANCH_TAKE : S_FETCH;
      I_BOV:                               nxt = v  ? S_BRANCH_TAKE : S_FETCH;
      I_BNOV:                              nxt = !v ? S_BRANCH_TAKE : S_FETCH;
      default:                             nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // Control word for a state. The ALU op is taken from the IR that is in
  // DECODE when ALU_WB is entered; the IR does not change until the next
  // LOAD_IR.
  function automatic ctrl_t ctrl_for(
    input state_t                  s,
    input decoded_instruction_type di
  );
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD_IR: begin
        c.ir_enable = 1'b1;
        c.pc_enable = 1'b1;
      end
      S_LOAD_WAIT: begin
        c.addr_sel = 1'b1;
      end
      S_LOAD_WB: begin
        c.addr_sel         = 1'b1;
        c.write_reg_enable = 1'b1;
      end
      S_STORE_WR: begin
        c.addr_sel         = 1'b1;
        c.ram_write_enable = 1'b1;
      end
      S_ALU_WB: begin
        c.c_sel            = 1'b1;
        c.write_reg_enable = 1'b1;
        c.operation        = alu_op_of(di);
        c.flags_reg_enable = (di != I_MOVE);
      end
      S_BRANCH_TAKE: begin
        c.branch    = 1'b1;
        c.pc_enable = 1'b1;
      end
      S_HALTED: begin
        c.halt = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:       if (wc_term) state_d = S_LOAD_IR;
      S_LOAD_IR:     state_d = S_DECODE;
      S_DECODE:      state_d = dispatch(decoded_instruction, zero_op, neg_op, signed_overflow);
      S_LOAD_WAIT:   if (wc_term) state_d = S_LOAD_WB;
      S_LOAD_WB,
      S_STORE_WR,
      S_ALU_WB,
      S_BRANCH_TAKE: state_d = S_FETCH;
      S_HALTED:      state_d = S_HALTED;
      default:       state_d = S_FETCH;
    endcase
  end

  assign wc_load     = (state_d != state_q);
  assign wc_term_val = (state_q == S_LOAD_WAIT) ? LW_TERM : FETCH_TERM;

  wait_counter u_wait_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (wc_load),
    .load_val_i ('0),
    .term_val_i (wc_term_val),
    .term_o     (wc_term)
  );

  // Outputs are registered from the next state so they line up with the
  // state they belong to without a combinational path from the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      ctrl_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, decoded_instruction);
      if (state_q == S_DECODE) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
    end
  end

  assign branch           = ctrl_q.branch;
  assign pc_enable        = ctrl_q.pc_enable;
  assign ir_enable        = ctrl_q.ir_enable;
  assign addr_sel         = ctrl_q.addr_sel;
  assign c_sel            = ctrl_q.c_sel;
  assign operation        = ctrl_q.operation;
  assign write_reg_enable = ctrl_q.write_reg_enable;
  assign flags_reg_enable = ctrl_q.flags_reg_enable;
  assign ram_write_enable = ctrl_q.ram_write_enable;
  assign halt             = ctrl_q.halt;
  assign instr_count      = instr_count_q;

endmodule

// File: tb/tb_control_unit_mc.sv
`timescale 1ns/1ps
module tb_control_unit_mc;
  import k_and_s_pkg::*;

  // Observed control vector layout (bit positions).
  localparam logic [10:0] O_BR   = 11'h400;
  localparam logic [10:0] O_PC   = 11'h200;
  localparam logic [10:0] O_IR   = 11'h100;
  localparam logic [10:0] O_ADDR = 11'h080;
  localparam logic [10:0] O_CSEL = 11'h040;
  localparam logic [10:0] O_OP1  = 11'h010;
  localparam logic [10:0] O_WRE  = 11'h008;
  localparam logic [10:0] O_FLG  = 11'h004;
  localparam logic [10:0] O_RWE  = 11'h002;
  localparam logic [10:0] O_HALT = 11'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  decoded_instruction_type di;
  logic zf, nf, uf, vf;

  logic br[3], pce[3], ire[3], asel[3], csel[3], wre[3], fre[3], rwe[3], hlt[3];
  logic [1:0] op[3];
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic [10:0] ov[3];
  logic [15:0] cv[3];

  int checks = 0;
  int failures = 0;
  int exp_cnt, cyc, n_flg, n_rwe, n_br, first_wre, first_halt;

  control_unit_mc #(.MEM_WAIT(0), .CNT_W(16)) u_w0 (
    .clk(clk), .rst(rst), .decoded_instruction(di),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(vf),
    .branch(br[0]), .pc_enable(pce[0]), .ir_enable(ire[0]), .addr_sel(asel[0]),
    .c_sel(csel[0]), .operation(op[0]), .write_reg_enable(wre[0]),
    .flags_reg_enable(fre[0]), .ram_write_enable(rwe[0]), .halt(hlt[0]),
    .instr_count(cnt_a));

  control_unit_mc #(.MEM_WAIT(2), .CNT_W(16)) u_w2 (
    .clk(clk), .rst(rst), .decoded_instruction(di),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(vf),
    .branch(br[1]), .pc_enable(pce[1]), .ir_enable(ire[1]), .addr_sel(asel[1]),
    .c_sel(csel[1]), .operation(op[1]), .write_reg_enable(wre[1]),
    .flags_reg_enable(fre[1]), .ram_write_enable(rwe[1]), .halt(hlt[1]),
    .instr_count(cnt_b));

  control_unit_mc #(.MEM_WAIT(3), .CNT_W(4)) u_w3 (
    .clk(clk), .rst(rst), .decoded_instruction(di),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(vf),
    .branch(br[2]), .pc_enable(pce[2]), .ir_enable(ire[2]), .addr_sel(asel[2]),
    .c_sel(csel[2]), .operation(op[2]), .write_reg_enable(wre[2]),
    .flags_reg_enable(fre[2]), .ram_write_enable(rwe[2]), .halt(hlt[2]),
    .instr_count(cnt_c));

  for (genvar g = 0; g < 3; g++) begin : g_ov
    assign ov[g] = {br[g], pce[g], ire[g], asel[g], csel[g], op[g],
                    wre[g], fre[g], rwe[g], hlt[g]};
  end
  assign cv[0] = cnt_a;
  assign cv[1] = cnt_b;
  assign cv[2] = {12'd0, cnt_c};

  function automatic int w_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic int cmask(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  // Branch decision straight from the instruction-set rules.
  function automatic bit taken(input decoded_instruction_type d, input bit z, input bit n, input bit v);
    case (d)
      I_BRANCH: return 1'b1;
      I_BZERO:  return z;
      I_BNZERO: return !z;
      I_BNEG:   return n;
      I_BNNEG:  return !n;
      I_BOV:    return v;
      I_BNOV:   return !v;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    di  = I_NOP;
    zf = 1'b0; nf = 1'b0; uf = 1'b0; vf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 11'd0 || cv[k] !== 16'd0) begin
        failures++;
        $display("FAIL reset k=%0d ctl=%h cnt=%0d required ctl=0 cnt=0", k, ov[k], cv[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; cyc = 0; n_flg = 0; n_rwe = 0; n_br = 0;
    first_wre = -1; first_halt = -1;
  endtask

  // Expected per-cycle trace of one instruction, built from the cycle tables
  // of the instruction set, then compared cycle by cycle against instance k.
  task automatic run_instr(input int k, input decoded_instruction_type d,
                           input bit z, input bit n, input bit v);
    logic [10:0] q[$];
    int w, dec_idx;
    w = w_of(k);
    for (int i = 0; i <= w; i++) q.push_back(11'd0);
    q.push_back(O_IR | O_PC);
    q.push_back(11'd0);
    dec_idx = w + 2;
    case (d)
      I_HALT:  q.push_back(O_HALT);
      I_LOAD: begin
        for (int i = 0; i < w; i++) q.push_back(O_ADDR);
        q.push_back(O_ADDR | O_WRE);
      end
      I_STORE: q.push_back(O_ADDR | O_RWE);
      I_MOVE:  q.push_back(O_CSEL | O_WRE);
      I_OR:    q.push_back(O_CSEL | O_WRE | O_FLG);
      I_ADD:   q.push_back(O_CSEL | O_WRE | O_FLG | O_OP1);
      I_SUB:   q.push_back(O_CSEL | O_WRE | O_FLG | (O_OP1 << 1));
      I_AND:   q.push_back(O_CSEL | O_WRE | O_FLG | (O_OP1 * 3));
      default: if (taken(d, z, n, v)) q.push_back(O_BR | O_PC);
    endcase
    di = d;
    foreach (q[i]) begin
      if (i == dec_idx) begin
        zf = z; nf = n; vf = v;
      end else begin
        zf = 1'($urandom); nf = 1'($urandom); vf = 1'($urandom);
      end
      uf = 1'($urandom);
      #1;
      cyc++;
      checks++;
      if (ov[k] !== q[i]) begin
        failures++;
        $display("FAIL ctl k=%0d instr=%0d cyc=%0d actual=%h required=%h", k, int'(d), cyc, ov[k], q[i]);
      end
      checks++;
      if (cv[k] !== 16'(exp_cnt)) begin
        failures++;
        $display("FAIL count k=%0d instr=%0d cyc=%0d actual=%0d required=%0d", k, int'(d), cyc, cv[k], exp_cnt);
      end
      if (i == dec_idx) exp_cnt = (exp_cnt + 1) & cmask(k);
      if (ov[k][2]) n_flg++;
      if (ov[k][1]) n_rwe++;
      if (ov[k][10]) n_br++;
      if (ov[k][3] && first_wre < 0) first_wre = cyc;
      if (ov[k][0] && first_halt < 0) first_halt = cyc;
      @(negedge clk);
    end
  endtask

  task automatic test_nop_add_halt();
    test_reset();
    run_instr(0, I_NOP, 1'($urandom), 1'($urandom), 1'($urandom));
    run_instr(0, I_ADD, 1'($urandom), 1'($urandom), 1'($urandom));
    run_instr(0, I_HALT, 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (first_halt !== 11) begin
      failures++;
      $display("FAIL halt_cycle actual=%0d required=11", first_halt);
    end
    #1;
    checks++;
    if (cv[0] !== 16'd3) begin
      failures++;
      $display("FAIL halt_count actual=%0d required=3", cv[0]);
    end
    checks++;
    if (n_flg !== 1) begin
      failures++;
      $display("FAIL flag_pulses actual=%0d required=1", n_flg);
    end
  endtask

  task automatic test_load_wait();
    test_reset();
    run_instr(1, I_LOAD, 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (first_wre !== 8) begin
      failures++;
      $display("FAIL load_wb_cycle actual=%0d required=8", first_wre);
    end
    run_instr(1, I_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    int c0;
    test_reset();
    c0 = cyc;
    run_instr(0, I_BZERO, 1'b1, 1'($urandom), 1'($urandom));
    checks++;
    if (cyc - c0 !== 4 || n_br !== 1) begin
      failures++;
      $display("FAIL bzero_taken cycles=%0d pulses=%0d required cycles=4 pulses=1", cyc - c0, n_br);
    end
    c0 = cyc;
    run_instr(0, I_BZERO, 1'b0, 1'($urandom), 1'($urandom));
    checks++;
    if (cyc - c0 !== 3 || n_br !== 1) begin
      failures++;
      $display("FAIL bzero_not_taken cycles=%0d pulses=%0d required cycles=3 pulses=1", cyc - c0, n_br);
    end
    run_instr(0, I_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_move_store();
    test_reset();
    run_instr(1, I_MOVE, 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (n_flg !== 0) begin
      failures++;
      $display("FAIL move_flags actual=%0d required=0", n_flg);
    end
    run_instr(1, I_STORE, 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (n_rwe !== 1) begin
      failures++;
      $display("FAIL store_pulses actual=%0d required=1", n_rwe);
    end
  endtask

  task automatic test_reset_mid_wait();
    test_reset();
    di = I_LOAD;
    // FETCH x4, LOAD_IR, DECODE, LOAD_WAIT #1 -> now in LOAD_WAIT #2 (cycle 8)
    for (int i = 0; i < 7; i++) @(negedge clk);
    #1;
    checks++;
    if (ov[2] !== O_ADDR || cv[2] !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset_wait ctl=%h cnt=%0d required ctl=%h cnt=1", ov[2], cv[2], O_ADDR);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov[2] !== 11'd0 || cv[2] !== 16'd0) begin
      failures++;
      $display("FAIL async_reset ctl=%h cnt=%0d required ctl=0 cnt=0", ov[2], cv[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; cyc = 0;
    run_instr(2, I_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count_wrap();
    test_reset();
    for (int i = 0; i < 17; i++)
      run_instr(2, I_NOP, 1'($urandom), 1'($urandom), 1'($urandom));
    run_instr(2, I_HALT, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 100; i++) begin
      di = decoded_instruction_type'(5'($urandom_range(0, 20)));
      zf = 1'($urandom); nf = 1'($urandom); uf = 1'($urandom); vf = 1'($urandom);
      #1;
      checks++;
      if (ov[2] !== O_HALT || cv[2] !== 16'd2) begin
        failures++;
        $display("FAIL halted_hold i=%0d ctl=%h cnt=%0d required ctl=%h cnt=2", i, ov[2], cv[2], O_HALT);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    decoded_instruction_type d;
    for (int k = 0; k < 3; k++) begin
      test_reset();
      for (int i = 0; i < 40; i++) begin
        d = decoded_instruction_type'(5'($urandom_range(0, 20)));
        run_instr(k, d, 1'($urandom), 1'($urandom), 1'($urandom));
        if (d == I_HALT) test_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_add_halt();
    test_load_wait();
    test_branch();
    test_move_store();
    test_reset_mid_wait();
    test_count_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle control unit for the K-and-S processor. It extends the basic fetch/decode/execute sequencer in three ways: a parametrised memory wait-state count, conditional and unconditional branches driven by the datapath flags, and a retired-instruction counter. It sits between the datapath, which supplies `decoded_instruction` and the registered flags, and the single-port program/data RAM. It drives every datapath enable plus `ram_write_enable` and `halt`.

## Interface
Parameters:
- `MEM_WAIT`, default 0: extra RAM read wait cycles, range 0..15.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `decoded_instruction`  in  `decoded_instruction_type`  current IR decode, from the datapath.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  in  1 each  registered flags from the datapath.
- `branch`  out  1  selects the branch target into the PC.
- `pc_enable`  out  1  PC load/increment.
- `ir_enable`  out  1  IR load.
- `addr_sel`  out  1  0 = PC drives the RAM address, 1 = IR address field drives it.
- `c_sel`  out  1  0 = RAM data to register write port, 1 = ALU result.
- `operation`  out  2  ALU op: 00 OR/pass, 01 ADD, 10 SUB, 11 AND.
- `write_reg_enable`  out  1  register file write.
- `flags_reg_enable`  out  1  flag register load.
- `ram_write_enable`  out  1  RAM write.
- `halt`  out  1  processor stopped.
- `instr_count`  out  `CNT_W`  number of instructions decoded since reset.

## Operation
- All outputs default to 0 in every state unless listed below. Reset drives state to FETCH, clears the wait counter and `instr_count`, and forces all outputs to 0.
- FETCH: `addr_sel`=0. Stays `MEM_WAIT`+1 cycles, counted by the wait counter, then moves to LOAD_IR.
- LOAD_IR: `ir_enable`=1 and `pc_enable`=1 for 1 cycle, then DECODE.
- DECODE: 1 cycle; increments `instr_count` (wraps modulo 2^`CNT_W`). Dispatch:
  - NOP → FETCH.
  - HALT → HALTED.
  - LOAD → LOAD_WAIT if `MEM_WAIT`>0, otherwise LOAD_WB.
  - STORE → STORE_WR.
  - ADD/SUB/AND/OR/MOVE → ALU_WB.
  - BRANCH → BRANCH_TAKE.
  - Conditional branches (BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV) sample `zero_op`, `neg_op`, `signed_overflow` in this cycle: condition true → BRANCH_TAKE, false → FETCH.
  - Unknown encodings behave as NOP.
- LOAD_WAIT: `addr_sel`=1 for `MEM_WAIT` cycles, then LOAD_WB.
- LOAD_WB: `addr_sel`=1, `c_sel`=0, `write_reg_enable`=1, then FETCH.
- STORE_WR: `addr_sel`=1, `ram_write_enable`=1, then FETCH. Writes need no wait states.
- ALU_WB: `c_sel`=1, `write_reg_enable`=1, `operation` per opcode (MOVE uses 00). `flags_reg_enable`=1 for ADD/SUB/AND/OR; MOVE leaves the flags unchanged. Then FETCH.
- BRANCH_TAKE: `branch`=1 and `pc_enable`=1, then FETCH.
- HALTED: `halt`=1. Absorbing; only `rst` leaves it, and `instr_count` freezes.
- The wait counter is 4 bits and reloads to 0 on every state entry.

## Timing
- Outputs are a Moore function of state and `decoded_instruction`; there is no combinational path from the flags to any output.
- Cycles per instruction (W = `MEM_WAIT`):
  - NOP and not-taken branch: W+3.
  - ALU, STORE, taken branch: W+4.
  - LOAD: 2W+4.
- `halt` rises on the cycle after HALT is in DECODE.
- Flags written in ALU_WB are visible to a conditional branch decoded in the very next instruction, because DECODE comes at least 3 cycles later.
- Asserting `rst` in any state, including mid-wait or during STORE_WR, drops all outputs immediately. No partial RAM write is guaranteed beyond that edge.

## Structure
- `k_and_s_pkg` holds `decoded_instruction_type`, extended with the branch and NOP encodings, and an `alu_op_t` enum for the 2-bit op codes.
- `state_t` is local to the module.
- One sub-module: `wait_counter`, a 4-bit loadable down-counter with a terminal flag, reused for FETCH and LOAD_WAIT.

## Test plan
- MEM_WAIT=0: stream NOP, ADD, HALT → `halt`=1 at cycle 11 after reset release; `instr_count`=3; `flags_reg_enable` pulses exactly once.
- MEM_WAIT=2: LOAD → `write_reg_enable` pulses at cycle 8 (2W+4 = 8) with `addr_sel`=1 and `c_sel`=0; `addr_sel`=1 in the two LOAD_WAIT cycles before it.
- BZERO with `zero_op`=1 → `branch`=1 and `pc_enable`=1 in one cycle. With `zero_op`=0 → no `branch` pulse, and the next FETCH starts 1 cycle earlier.
- MOVE → `write_reg_enable`=1, `operation`=00, `flags_reg_enable` stays 0; STORE → `ram_write_enable` high for exactly 1 cycle.
- `rst` asserted for 1 cycle during LOAD_WAIT (MEM_WAIT=3) → all outputs 0 asynchronously, `instr_count`=0, and fetch restarts with `addr_sel`=0.
- CNT_W=4: 17 NOPs then HALT → `instr_count` wraps to 2 at halt; `halt` stays 1 for 100 cycles with no other outputs active.
